// File: rtl/regfile_uart_dump.sv
// Walks 8 register-file entries and sends "Rn=HH\r\n" per entry as 8N1 serial on txd.
// Accepts start only in IDLE; each char takes 10*CLKS_PER_BIT cycles, back-to-back, done pulses once at the end.
module regfile_uart_dump #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] ra,
  input  logic [7:0] rd,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA,
    S_STOP_BIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [2:0]    r_char;
  logic [2:0]    r_rec;
  logic [7:0]    r_data;
  logic          r_txd;

  state_t        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [2:0]    w_char_nxt;
  logic [2:0]    w_rec_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_txd_nxt;
  logic [7:0]    w_char;
  logic          w_bit_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character currently on the line, selected by position within the record
  always_comb begin
    w_char = 8'h0A;
    case (r_char)
      3'd0:    w_char = 8'h52;
      3'd1:    w_char = 8'h30 + {5'b0, r_rec};
      3'd2:    w_char = 8'h3D;
      3'd3:    w_char = hex_ascii(r_data[7:4]);
      3'd4:    w_char = hex_ascii(r_data[3:0]);
      3'd5:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  assign w_bit_end = (r_baud == BAUD_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_char_nxt  = r_char;
    w_rec_nxt   = r_rec;
    w_data_nxt  = r_data;
    w_txd_nxt   = r_txd;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (start) begin
          w_state_nxt = S_START_BIT;
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_char_nxt  = 3'd0;
          w_rec_nxt   = 3'd0;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START_BIT: begin
        w_baud_nxt = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
          w_txd_nxt   = w_char[0];
        end
      end
      S_DATA: begin
        w_baud_nxt = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP_BIT;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_txd_nxt = w_char[3'(r_bit + 3'd1)];
          end
        end
      end
      S_STOP_BIT: begin
        w_baud_nxt = r_baud + 1'b1;
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_char == 3'd6) begin
            if (r_rec == 3'd7) begin
              w_state_nxt = S_DONE;
            end else begin
              w_rec_nxt   = r_rec + 3'd1;
              w_char_nxt  = 3'd0;
              w_state_nxt = S_START_BIT;
              w_txd_nxt   = 1'b0;
            end
          end else begin
            // Snapshot rd as '=' begins so both hex digits agree
            if (r_char == 3'd1) w_data_nxt = rd;
            w_char_nxt  = r_char + 3'd1;
            w_state_nxt = S_START_BIT;
            w_txd_nxt   = 1'b0;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_char  <= 3'd0;
      r_rec   <= 3'd0;
      r_data  <= 8'h00;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_char  <= w_char_nxt;
      r_rec   <= w_rec_nxt;
      r_data  <= w_data_nxt;
      r_txd   <= w_txd_nxt;
    end
  end

  assign ra   = r_rec;
  assign txd  = r_txd;
  assign busy = (r_state == S_START_BIT) || (r_state == S_DATA) || (r_state == S_STOP_BIT);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Bench for regfile_uart_dump: UART receiver model decodes txd and compares against text built from register contents.
module tb_regfile_uart_dump;

  localparam int CPB = 4;
  localparam int DUMP_CYC = 560 * CPB;

  logic       clk = 1'b0;
  logic       rst, start, rst2, start2;
  logic [2:0] ra, ra2;
  logic [7:0] rd, rd2;
  logic       txd, busy, done, txd2, busy2, done2;
  logic [7:0] regs [8];

  assign rd  = regs[ra];
  assign rd2 = regs[ra2];

  regfile_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd),
    .txd(txd), .busy(busy), .done(done)
  );

  regfile_uart_dump #(.CLKS_PER_BIT(434)) dut434 (
    .clk(clk), .rst(rst2), .start(start2), .ra(ra2), .rd(rd2),
    .txd(txd2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit done_prev = 0;
  bit done_wide = 0;
  byte rxq [$];
  bit  rx_ok;
  int  acc_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) done_wide = 1;
    end
    done_prev = (done === 1'b1);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string model_str();
    string hx = "0123456789ABCDEF";
    string s = "";
    for (int n = 0; n < 8; n++)
      s = {s, "R", $sformatf("%0d", n), "=", hx.substr(regs[n][7:4], regs[n][7:4]),
           hx.substr(regs[n][3:0], regs[n][3:0]), "\r\n"};
    return s;
  endfunction

  // Receive one 8N1 character, checking every bit is stable over its full period
  task automatic rx_char(input int idx, input bit first, output byte c, output bit ok);
    int w = 0;
    bit unstable = 0;
    logic [9:0] b;
    ok = 1;
    c = 0;
    b = '0;
    @(negedge clk);
    while (txd !== 1'b0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (txd !== 1'b0) begin
      chk("rx_start_timeout", 32'(w), 32'd0);
      ok = 0;
      return;
    end
    if (idx % 7 == 0) chk($sformatf("ra_rec%0d", idx / 7), 32'(ra), 32'(idx / 7));
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k % CPB == 0) b[k / CPB] = txd;
      else if (txd !== b[k / CPB]) unstable = 1;
    end
    c = b[8:1];
    if (first) w = 0;
    chk($sformatf("frame%0d", idx), {unstable, b[0], b[9], 29'(w)}, {1'b0, 1'b0, 1'b1, 29'd0});
    ok = (b[0] === 1'b0) && (b[9] === 1'b1);
  endtask

  task automatic rx_dump();
    byte c;
    bit  okc;
    rxq.delete();
    rx_ok = 1;
    for (int i = 0; i < 56; i++) begin
      rx_char(i, i == 0, c, okc);
      if (!okc) begin
        rx_ok = 0;
        return;
      end
      rxq.push_back(c);
    end
  endtask

  task automatic cmp_text(input string name, input string exp);
    int bad = -1;
    for (int i = 0; i < exp.len() && i < rxq.size(); i++)
      if (bad < 0 && rxq[i] !== exp[i]) bad = i;
    checks++;
    if (!rx_ok || rxq.size() != exp.len() || bad >= 0) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s: char %0d got %02h expected %02h", name, bad, rxq[bad], exp[bad]);
      else
        $display("FAIL %s: got %0d chars expected %0d", name, rxq.size(), exp.len());
    end
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    at = -1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done === 1'b1) at = cyc;
  endtask

  // mode 0 plain, 1 start pulses during dump, 2 rd change after '=' edge of record 2, 3 just before it
  task automatic run_dump(input string name, input string exp, input int mode);
    int dc0, at;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    dc0 = done_cnt;
    done_wide = 0;
    chk({name, "_accept"}, {29'd0, busy, txd, 2'(ra)}, {29'd0, 1'b1, 1'b0, 2'd0});
    fork
      rx_dump();
      begin
        if (mode == 1) begin
          for (int p = 0; p < 20; p++) begin
            repeat (97) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
          end
        end else if (mode == 2 || mode == 3) begin
          repeat (mode == 2 ? 16 * 10 * CPB : 16 * 10 * CPB - 1) @(posedge clk);
          #1;
          regs[2] = 8'h77;
        end
      end
    join
    wait_done(at);
    chk({name, "_done_lat"}, 32'(at - acc_cyc), 32'(DUMP_CYC));
    chk({name, "_done_state"}, {30'd0, busy, txd}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    chk({name, "_done_cnt"}, 32'(done_cnt - dc0), 32'd1);
    chk({name, "_done_width"}, 32'(done_wide), 32'd0);
    cmp_text({name, "_text"}, exp);
    if (mode == 1) begin
      repeat (50) @(negedge clk);
      chk({name, "_no_requeue"}, {30'd0, busy, txd}, {30'd0, 1'b0, 1'b1});
    end
  endtask

  typedef struct {
    logic [63:0] r;
    string       exp;
  } vec_t;

  vec_t vt [2];

  task automatic load_regs(input logic [63:0] r);
    for (int n = 0; n < 8; n++) regs[n] = r[8*n +: 8];
  endtask

  initial begin
    string exp;
    int at, lo, hi, dc0;

    vt[0].r   = 64'hFFFE_A580_3F2A_1100;
    vt[0].exp = "R0=00\r\nR1=11\r\nR2=2A\r\nR3=3F\r\nR4=80\r\nR5=A5\r\nR6=FE\r\nR7=FF\r\n";
    vt[1].r   = 64'hEFCD_AB89_6745_2301;
    vt[1].exp = "R0=01\r\nR1=23\r\nR2=45\r\nR3=67\r\nR4=89\r\nR5=AB\r\nR6=CD\r\nR7=EF\r\n";

    rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;
    load_regs(vt[0].r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, txd, busy, done, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_ra", 32'(ra), 32'd0);
    rst = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < 2; i++) begin
      load_regs(vt[i].r);
      run_dump($sformatf("vec%0d", i), vt[i].exp, 0);
    end

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 8; n++) regs[n] = 8'($urandom_range(0, 255));
      run_dump($sformatf("rand%0d", k), model_str(), 0);
    end

    load_regs(vt[0].r);
    run_dump("rd_after", model_str(), 2);
    regs[2] = 8'h77;
    exp = model_str();
    regs[2] = 8'h2A;
    run_dump("rd_before", exp, 3);
    regs[2] = 8'h2A;

    run_dump("start_pulses", model_str(), 1);

    // start held high: the cycle after done is IDLE, next edge re-accepts
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    rx_dump();
    cmp_text("held_text", model_str());
    wait_done(at);
    chk("held_done_lat", 32'(at - acc_cyc), 32'(DUMP_CYC));
    @(negedge clk);
    chk("held_idle_gap", {29'd0, done, busy, txd}, {29'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("held_restart", {29'd0, busy, txd, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("held_restart_ra", 32'(ra), 32'd0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // reset during DATA of character 20 (LF of record 2, bit0 low)
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc0 = done_cnt;
    repeat (20 * 10 * CPB + CPB + 2) @(posedge clk);
    #1;
    chk("pre_rst_state", {29'd0, busy, txd, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("pre_rst_ra", 32'(ra), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_state", {29'd0, txd, busy, done}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("mid_rst_ra", 32'(ra), 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - dc0), 32'd0);
    run_dump("after_rst", model_str(), 0);

    // reset and start on the same edge: reset wins, start not remembered
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_start_same", {30'd0, busy, txd}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_start_after", {30'd0, busy, txd}, {30'd0, 1'b0, 1'b1});

    // 434-cycle bit period: 'R' = start 0, bit0 0, bit1 1, bit2 0
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    chk("b434_accept", {30'd0, busy2, txd2}, {30'd0, 1'b1, 1'b0});
    lo = 0;
    hi = 0;
    @(negedge clk);
    while (txd2 === 1'b0 && lo < 2000) begin
      lo++;
      @(negedge clk);
    end
    while (txd2 === 1'b1 && hi < 2000) begin
      hi++;
      @(negedge clk);
    end
    chk("b434_start_plus_bit0", 32'(lo), 32'd868);
    chk("b434_bit1", 32'(hi), 32'd434);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("b434_reset", {29'd0, busy2, txd2, done2}, {29'd0, 1'b0, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
